fnd_scan_controller: RTL and testbench
======================================

// Module: fnd_scan_controller
// PURPOSE
// - Time-multiplexed scan driver for the 4-digit FND. Generates the 3-bit select consumed by the
//   FND digit decoder (0-3 = digit slots, 4-7 = dot slots, same positions) plus the per-slot BCD/dot data.
// - Inserts a blanking interval at every select change to prevent ghosting.
// - Latches display data once per frame so a frame never mixes old and new digits.
// PARAMETERS
// - TICK_DIV      100_000  clock cycles per slot (blank + show); must be > BLANK_CYCLES+1
// - BLANK_CYCLES  16       cycles per slot with o_blank=1 at slot start; must be >= 1
// PORTS
// - i_clk         in   1   system clock, rising edge
// - i_reset_n     in   1   asynchronous, active-low reset
// - i_enable      in   1   1 = scan, 0 = display off
// - i_digit       in   16  BCD nibbles; [3:0] = digit 0 ... [15:12] = digit 3
// - i_dot_mask    in   4   1 = light dot of digit k
// - o_select      out  3   slot index to the digit decoder
// - o_bcd         out  4   segment-decoder value for this slot; 4'hF = blank code
// - o_dot         out  1   dot request for this slot
// - o_blank       out  1   1 = downstream forces all digit enables off
// - o_frame_done  out  1   1-cycle pulse on the last cycle of a frame
// BEHAVIOUR
// - Reset is asynchronous, active-low. Reset values: o_select=0, o_bcd=4'hF, o_dot=0, o_blank=1,
//   o_frame_done=0, state=IDLE, counters=0, shadow registers=0. All outputs are registered.
// - States:
//   - IDLE: o_blank=1, o_select=0. Entered from reset or when i_enable=0.
//   - BLANK: o_blank=1 for exactly BLANK_CYCLES cycles.
//   - SHOW: o_blank=0 for TICK_DIV-BLANK_CYCLES cycles. At the end, advance to the next slot and go to BLANK.
// - Slot length is exactly TICK_DIV cycles. The cycle counter is $clog2(TICK_DIV) bits and clears at each slot boundary.
// - IDLE->BLANK: on the first cycle i_enable=1 is sampled. Slot 0 is then presented, and the shadow
//   registers capture i_digit/i_dot_mask.
// - Any state->IDLE: i_enable=0 sampled -> next cycle IDLE. A slot in progress is abandoned, not finished.
// - Slot sequence: 0,1,2,3,4,5,6,7, then wrap to 0.
//   - The shadow registers recapture on the same edge that o_select wraps to 0.
//   - Input changes mid-frame have no visible effect until the next frame.
// - Slot data:
//   - s<4: o_bcd = shadow nibble s, o_dot=0.
//   - s>=4: o_bcd = 4'hF, o_dot = shadow_dot[s-4].
//   - o_bcd/o_dot/o_select change only on the edge entering BLANK, never while o_blank=0.
// - o_frame_done: high on the last SHOW cycle of the final slot of a frame (slot 7 by default).
//   Not asserted for a frame aborted by i_enable=0.
// - Reset mid-scan: immediate return to reset values, whatever the state.
// CONFIGURATION
// - FND_DOT_SKIP_EN defined: a dot slot 4+k whose shadow_dot[k]=0 is skipped entirely.
//   - Advance from slot s goes to the next slot in 4..7 with its mask bit set, otherwise wraps to 0.
//   - If the mask is 0, the frame is slots 0-3 only, and o_frame_done fires at the end of slot 3.
//   - The skip decision uses the shadow (frame-latched) mask.
// - FND_DOT_SKIP_EN undefined: all 8 slots are always scanned. Unlit dot slots still occupy TICK_DIV cycles with o_dot=0.
// TESTING (TICK_DIV=8, BLANK_CYCLES=2)
// - Reset held, then released with i_enable=0 -> o_blank=1, o_select=0, o_bcd=F, o_dot=0, o_frame_done=0 indefinitely.
// - i_digit=16'h1234, i_dot_mask=4'b0101, enable -> o_select 0..7, each slot 8 cycles (2 blank, 6 show).
//   Expected o_bcd 4,3,2,1,F,F,F,F. Expected o_dot 0,0,0,0,1,0,1,0.
//   o_frame_done pulses once per 64 cycles.
// - Change i_digit to 16'h5678 during slot 2 -> remainder of frame still shows 2,1. Next frame shows 8,7,6,5.
// - Drop i_enable during SHOW of slot 5 -> next cycle o_blank=1, o_select=0, no o_frame_done.
//   Re-enable -> scan restarts at slot 0 with 2 blank cycles.
// - Assert i_reset_n=0 mid-SHOW (asynchronous, between clock edges) -> outputs reach reset values
//   before the next clock edge.
// - FND_DOT_SKIP_EN, i_dot_mask=4'b1000 -> slot order 0,1,2,3,7,0. Frame is 40 cycles.
//   With mask 0: slot order 0-3, frame is 32 cycles.

Source files
------------

// File: rtl/fnd_scan_if.sv
// Bus between the FND scan controller and its user / downstream digit decoder.
// The driver side (display data source, decoder sink) uses the master modport;
// the scan controller itself uses the slave modport.
interface fnd_scan_if;
  logic        i_enable;
  logic [15:0] i_digit;
  logic [3:0]  i_dot_mask;
  logic [2:0]  o_select;
  logic [3:0]  o_bcd;
  logic        o_dot;
  logic        o_blank;
  logic        o_frame_done;

  modport master (
    output i_enable, i_digit, i_dot_mask,
    input  o_select, o_bcd, o_dot, o_blank, o_frame_done
  );

  modport slave (
    input  i_enable, i_digit, i_dot_mask,
    output o_select, o_bcd, o_dot, o_blank, o_frame_done
  );
endinterface

// File: rtl/fnd_scan_controller.sv
// Time-multiplexed scan driver for a 4-digit FND: 4 digit slots then 4 dot slots,
// each slot a blanking interval followed by a show interval, with display data
// latched once per frame.
// Optional feature macro: FND_DOT_SKIP_EN (skip dot slots whose latched mask bit is 0).
module fnd_scan_controller #(
  parameter int unsigned TICK_DIV     = 100_000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  fnd_scan_if.slave   bus
);

  localparam int unsigned CW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    slot, slot_d, slot_adv;
  logic [15:0]   sh_digit, sh_digit_d;
  logic [3:0]    sh_dot, sh_dot_d;
  logic          capture;
  logic [3:0]    bcd_q, bcd_d;
  logic          dot_q, dot_d;
  logic          blank_q, blank_d;
  logic          done_q, done_d;
  logic          blank_end, slot_end, slot_prelast;

  assign blank_end    = (cnt == CW'(BLANK_CYCLES - 1));
  assign slot_end     = (cnt == CW'(TICK_DIV - 1));
  assign slot_prelast = (cnt == CW'(TICK_DIV - 2));

  assign bus.o_select     = slot;
  assign bus.o_bcd        = bcd_q;
  assign bus.o_dot        = dot_q;
  assign bus.o_blank      = blank_q;
  assign bus.o_frame_done = done_q;

  // State register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_d;
  end

  // Next-state logic; a low enable abandons the slot in progress
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (bus.i_enable) state_d = BLANK;
      BLANK:   if (!bus.i_enable) state_d = IDLE;
               else if (blank_end) state_d = SHOW;
      SHOW:    if (!bus.i_enable) state_d = IDLE;
               else if (slot_end) state_d = BLANK;
      default: state_d = IDLE;
    endcase
  end

  // Slot following the current one; a result of 0 means the frame wraps
  always_comb begin
    slot_adv = 3'd0;
`ifdef FND_DOT_SKIP_EN
    if (slot < 3'd3) begin
      slot_adv = slot + 3'd1;
    end else begin
      for (int k = 3; k >= 0; k--) begin
        if (sh_dot[k] && ((3'(k) + 3'd4) > slot)) slot_adv = 3'(k) + 3'd4;
      end
    end
`else
    slot_adv = slot + 3'd1;
`endif
  end

  // Output / datapath next values; slot data only moves on the edge entering BLANK
  always_comb begin
    cnt_d   = cnt;
    slot_d  = slot;
    capture = 1'b0;
    done_d  = 1'b0;
    if (!bus.i_enable) begin
      cnt_d  = '0;
      slot_d = 3'd0;
    end else begin
      case (state)
        IDLE: begin
          cnt_d   = '0;
          slot_d  = 3'd0;
          capture = 1'b1;
        end
        BLANK: cnt_d = cnt + CW'(1);
        SHOW: begin
          done_d = slot_prelast && (slot_adv == 3'd0);
          if (slot_end) begin
            cnt_d   = '0;
            slot_d  = slot_adv;
            capture = (slot_adv == 3'd0);
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
        default: cnt_d = '0;
      endcase
    end

    sh_digit_d = capture ? bus.i_digit    : sh_digit;
    sh_dot_d   = capture ? bus.i_dot_mask : sh_dot;

    blank_d = (state_d != SHOW);
    if (state_d == IDLE) begin
      bcd_d = 4'hF;
      dot_d = 1'b0;
    end else if (slot_d[2]) begin
      bcd_d = 4'hF;
      dot_d = sh_dot_d[slot_d[1:0]];
    end else begin
      bcd_d = sh_digit_d[{slot_d[1:0], 2'b00} +: 4];
      dot_d = 1'b0;
    end
  end

  // Datapath and output registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt      <= '0;
      slot     <= 3'd0;
      sh_digit <= 16'h0000;
      sh_dot   <= 4'h0;
      bcd_q    <= 4'hF;
      dot_q    <= 1'b0;
      blank_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      cnt      <= cnt_d;
      slot     <= slot_d;
      sh_digit <= sh_digit_d;
      sh_dot   <= sh_dot_d;
      bcd_q    <= bcd_d;
      dot_q    <= dot_d;
      blank_q  <= blank_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed bench for fnd_scan_controller with TICK_DIV=8, BLANK_CYCLES=2.
// Dot-skip scenarios run only when FND_DOT_SKIP_EN is defined.
module tb_fnd_scan_controller;

  localparam int TICK  = 8;
  localparam int BLANK = 2;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  fnd_scan_if bus ();

  fnd_scan_controller #(.TICK_DIV(TICK), .BLANK_CYCLES(BLANK)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Checks the idle/reset output values at the current instant
  task automatic check_idle(input string tag);
    check({tag, "_select"}, int'(bus.o_select), 0);
    check({tag, "_bcd"},    int'(bus.o_bcd), 15);
    check({tag, "_dot"},    int'(bus.o_dot), 0);
    check({tag, "_blank"},  int'(bus.o_blank), 1);
    check({tag, "_done"},   int'(bus.o_frame_done), 0);
  endtask

  // Checks the first n cycles of one slot (sampled on the falling edge)
  task automatic check_slot(input int s, input int bcd, input int dot, input bit last, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("select", int'(bus.o_select), s);
      check("blank",  int'(bus.o_blank), (k < BLANK) ? 1 : 0);
      check("bcd",    int'(bus.o_bcd), bcd);
      check("dot",    int'(bus.o_dot), dot);
      check("frame_done", int'(bus.o_frame_done), (last && k == TICK - 1) ? 1 : 0);
    end
  endtask

  int bcd_a [8] = '{4, 3, 2, 1, 15, 15, 15, 15};
  int bcd_b [8] = '{8, 7, 6, 5, 15, 15, 15, 15};
  int dot_a [8] = '{0, 0, 0, 0, 1, 0, 1, 0};

  initial begin
    rst_n          = 1'b0;
    bus.i_enable   = 1'b0;
    bus.i_digit    = 16'h1234;
    bus.i_dot_mask = 4'b0101;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_idle("idle");
    end

    // Frame 1 with 1234 / 0101; digits change during slot 2 with no effect
    bus.i_enable = 1'b1;
    for (int s = 0; s < 8; s++) begin
      check_slot(s, bcd_a[s], dot_a[s], s == 7, TICK);
      if (s == 2) bus.i_digit = 16'h5678;
    end
    // Frame 2 shows the new digits
    for (int s = 0; s < 8; s++) check_slot(s, bcd_b[s], dot_a[s], s == 7, TICK);

    // Abort during SHOW of slot 5
    for (int s = 0; s < 5; s++) check_slot(s, bcd_b[s], dot_a[s], 1'b0, TICK);
    check_slot(5, 15, 0, 1'b0, 4);
    bus.i_enable = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_idle("abort");
    end

    // Re-enable restarts at slot 0 with a fresh capture
    bus.i_digit  = 16'h9abc;
    bus.i_enable = 1'b1;
    check_slot(0, 12, 0, 1'b0, TICK);
    check_slot(1, 11, 0, 1'b0, 5);

    // Asynchronous reset between clock edges during SHOW
    #2 rst_n = 1'b0;
    #1 check_idle("async_rst");
    check("async_rst_tmp", int'(bus.o_blank), 1);
    bus.i_enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_rst");

`ifdef FND_DOT_SKIP_EN
    // Mask 1000: slots 0,1,2,3,7 then wrap; mask cleared during slot 7
    bus.i_digit    = 16'h1234;
    bus.i_dot_mask = 4'b1000;
    bus.i_enable   = 1'b1;
    for (int s = 0; s < 4; s++) check_slot(s, bcd_a[s], 0, 1'b0, TICK);
    check_slot(7, 15, 1, 1'b1, TICK);
    bus.i_dot_mask = 4'b0000;
    // Mask 0: frame is slots 0-3 only
    for (int s = 0; s < 4; s++) check_slot(s, bcd_a[s], 0, s == 3, TICK);
    check_slot(0, 4, 0, 1'b0, 3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout at %0t: got running expected finished", $time);
    $fatal(1, "timeout");
  end

endmodule
